// File: rtl/window_accumulator.sv
// Sums a window of 2**LOGN qualified samples and holds sum/average until taken (valid/ready).
// Result is registered on the edge of the last sample; samples arriving while a result waits are dropped (sticky flag).
module window_accumulator #(
  parameter int SIZE = 5,
  parameter int LOGN = 2
) (
  input  logic                 clk,
  input  logic                 CLR,
  input  logic [SIZE-1:0]      din,
  input  logic                 din_valid,
  input  logic                 out_ready,
  output logic [SIZE+LOGN-1:0] sum_out,
  output logic [SIZE-1:0]      avg_out,
  output logic                 out_valid,
  output logic                 busy,
  output logic                 dropped
);

  localparam int SW = SIZE + LOGN;
  localparam logic [LOGN-1:0] LAST = {LOGN{1'b1}};
  localparam logic [LOGN-1:0] ONE  = LOGN'(1);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  state_t            state, state_nxt;
  logic [SW-1:0]     sum, sum_nxt;
  logic [LOGN-1:0]   count, count_nxt;
  logic [SW-1:0]     sum_out_nxt;
  logic [SIZE-1:0]   avg_out_nxt;
  logic              dropped_nxt;
  logic [SW-1:0]     din_ext;
  logic [SW-1:0]     sum_add;

  assign din_ext = {{LOGN{1'b0}}, din};
  assign sum_add = sum + din_ext;

  always_ff @(posedge clk or posedge CLR) begin
    if (CLR) begin
      state     <= IDLE;
      sum       <= '0;
      count     <= '0;
      sum_out   <= '0;
      avg_out   <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      dropped   <= 1'b0;
    end else begin
      state     <= state_nxt;
      sum       <= sum_nxt;
      count     <= count_nxt;
      sum_out   <= sum_out_nxt;
      avg_out   <= avg_out_nxt;
      out_valid <= (state_nxt == HOLD);
      busy      <= (state_nxt == ACCUM);
      dropped   <= dropped_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    sum_nxt     = sum;
    count_nxt   = count;
    sum_out_nxt = sum_out;
    avg_out_nxt = avg_out;
    dropped_nxt = dropped;
    case (state)
      IDLE: begin
        sum_nxt   = '0;
        count_nxt = '0;
        if (din_valid) begin
          sum_nxt   = din_ext;
          count_nxt = ONE;
          state_nxt = ACCUM;
        end
      end
      ACCUM: begin
        if (din_valid) begin
          sum_nxt   = sum_add;
          count_nxt = count + ONE;
          if (count == LAST) begin
            state_nxt   = HOLD;
            sum_out_nxt = sum_add;
            avg_out_nxt = sum_add[SW-1:LOGN];
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          // A sample on the handshake edge opens the next window instead of being lost.
          if (din_valid) begin
            sum_nxt   = din_ext;
            count_nxt = ONE;
            state_nxt = ACCUM;
          end else begin
            sum_nxt   = '0;
            count_nxt = '0;
            state_nxt = IDLE;
          end
        end else if (din_valid) begin
          dropped_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        sum_nxt   = '0;
        count_nxt = '0;
      end
    endcase
  end

endmodule
